// File: rtl/fifo_rd_framer.sv
// ============================================================================
// Module   : fifo_rd_framer
// Purpose  : Read-side consumer for an async FIFO. Pops words into a 2-entry
//            skid buffer and presents them on a registered valid/ready
//            stream. Every pkt_len-th beat is tagged as last. The FIFO pop
//            strobe never depends on downstream ready.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  fifo_rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  busy
);

    // Buffer occupancy doubles as the control state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam logic [LEN_WIDTH-1:0] C_LEN_ONE = LEN_WIDTH'(1);

    occ_t                  r_occ;
    occ_t                  w_occ_nxt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_ld_a_in;   // slot A <- incoming FIFO word
    logic                  w_ld_a_b;    // slot A <- slot B (skid drain)
    logic                  w_ld_b;      // slot B <- incoming FIFO word

    logic [DATA_WIDTH-1:0] r_a_data;
    logic                  r_a_last;
    logic [DATA_WIDTH-1:0] r_b_data;
    logic                  r_b_last;

    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  r_len_cur;
    logic [LEN_WIDTH-1:0]  w_len_eff;
    logic                  w_last_in;

    logic [CNT_WIDTH-1:0]  r_word_cnt;

    // Pop strobe uses registered occupancy only; reset gates it so no word is
    // consumed while the buffer is being cleared.
    assign w_push    = rrst_n & enable & ~fifo_rempty & (r_occ != FULL);
    assign w_pop     = m_valid & m_ready;

    assign fifo_rinc = w_push;
    assign m_valid   = (r_occ != EMPTY);
    assign m_data    = r_a_data;
    assign m_last    = r_a_last;
    assign word_cnt  = r_word_cnt;
    assign busy      = (r_occ != EMPTY) | (r_beat_cnt != '0);

    // Packet length is sampled on the first beat of a packet, so a pkt_len
    // change mid-packet only affects the following packet. Zero means one.
    assign w_len_eff = (r_beat_cnt == '0)
                     ? ((pkt_len == '0) ? C_LEN_ONE : pkt_len)
                     : r_len_cur;
    assign w_last_in = (r_beat_cnt == (w_len_eff - C_LEN_ONE));

    // Occupancy state register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_occ <= EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    // Next occupancy and slot load selects from the push/pop pair.
    always_comb begin
        w_occ_nxt = r_occ;
        w_ld_a_in = 1'b0;
        w_ld_a_b  = 1'b0;
        w_ld_b    = 1'b0;
        case (r_occ)
            EMPTY: begin
                if (w_push) begin
                    w_occ_nxt = ONE;
                    w_ld_a_in = 1'b1;
                end
            end
            ONE: begin
                if (w_push && !w_pop) begin
                    w_occ_nxt = FULL;
                    w_ld_b    = 1'b1;
                end else if (w_push && w_pop) begin
                    w_ld_a_in = 1'b1;
                end else if (w_pop) begin
                    w_occ_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_occ_nxt = ONE;
                    w_ld_a_b  = 1'b1;
                end
            end
            default: begin
                w_occ_nxt = EMPTY;
            end
        endcase
    end

    // Head and skid slots; each holds {last, data}.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_a_data <= '0;
            r_a_last <= 1'b0;
            r_b_data <= '0;
            r_b_last <= 1'b0;
        end else begin
            if (w_ld_a_in) begin
                r_a_data <= fifo_rdata;
                r_a_last <= w_last_in;
            end else if (w_ld_a_b) begin
                r_a_data <= r_b_data;
                r_a_last <= r_b_last;
            end
            if (w_ld_b) begin
                r_b_data <= fifo_rdata;
                r_b_last <= w_last_in;
            end
        end
    end

    // Beat position within the current packet, advanced on each push.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_beat_cnt <= '0;
            r_len_cur  <= C_LEN_ONE;
        end else if (w_push) begin
            r_len_cur  <= w_len_eff;
            r_beat_cnt <= w_last_in ? '0 : (r_beat_cnt + C_LEN_ONE);
        end
    end

    // Count of beats accepted downstream, wrapping naturally.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_framer.sv
// ============================================================================
// Module   : tb_fifo_rd_framer
// Purpose  : Scoreboard bench for fifo_rd_framer with a queue-based FIFO and
//            a packet-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_framer;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          enable;
    logic [LW-1:0] pkt_len;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rempty;
    logic          fifo_rinc;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] word_cnt;
    logic          busy;

    fifo_rd_framer #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .enable      (enable),
        .pkt_len     (pkt_len),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .word_cnt    (word_cnt),
        .busy        (busy)
    );

    always #5 rclk = ~rclk;

    // Environment FIFO contents and per-phase stimulus knobs.
    logic [DW-1:0] fifo_q[$];
    bit            pending_pop = 1'b0;
    int            ready_pct   = 100;
    int            en_pct      = 100;
    int            fill_pct    = 0;
    bit            len_rand    = 1'b0;
    logic [DW-1:0] next_word   = 8'h01;

    // Reference model: words handed out of the FIFO awaiting acceptance,
    // position inside the current packet, and accepted-beat total.
    logic [DW:0]   exp_q[$];
    int            pos     = 0;
    int            cur_len = 1;
    int            model_wc = 0;

    int            vectors    = 0;
    int            miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the model, then advances the model by
    // the transfers that happen at the next rising edge.
    task automatic check_cycle();
        bit          exp_rinc;
        bit          exp_pop;
        bit          lst;
        logic [DW:0] head;
        if (!rrst_n) begin
            exp_q.delete();
            pos         = 0;
            model_wc    = 0;
            pending_pop = 1'b0;
            check("rst_rinc",  32'(fifo_rinc), 32'd0);
            check("rst_valid", 32'(m_valid),   32'd0);
            check("rst_wcnt",  32'(word_cnt),  32'd0);
            check("rst_busy",  32'(busy),      32'd0);
            check("rst_data",  32'(m_data),    32'd0);
            return;
        end
        exp_rinc = enable && (fifo_q.size() != 0) && (exp_q.size() < 2);
        check("rinc",  32'(fifo_rinc), 32'(exp_rinc));
        check("valid", 32'(m_valid),   32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("data", 32'(m_data), 32'(head[DW-1:0]));
            check("last", 32'(m_last), 32'(head[DW]));
        end
        check("wcnt", 32'(word_cnt), 32'(model_wc % (1 << CW)));
        check("busy", 32'(busy), 32'((exp_q.size() != 0) || (pos != 0)));

        exp_pop = (exp_q.size() != 0) && m_ready;
        if (exp_pop) begin
            void'(exp_q.pop_front());
            model_wc++;
        end
        if (exp_rinc) begin
            if (pos == 0) cur_len = (pkt_len == 0) ? 1 : int'(pkt_len);
            lst = (pos + 1 == cur_len);
            pos = lst ? 0 : pos + 1;
            exp_q.push_back({lst, fifo_q[0]});
            pending_pop = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge rclk);
            #2;
            check_cycle();
        end
    end

    task automatic drive_pins();
        fifo_rempty = (fifo_q.size() == 0);
        fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // One stimulus step, applied shortly after the falling edge.
    task automatic cycle_drive(input bit rst_val);
        @(negedge rclk);
        #1;
        if (pending_pop) begin
            void'(fifo_q.pop_front());
            pending_pop = 1'b0;
        end
        if ($urandom_range(99) < fill_pct) begin
            fifo_q.push_back(next_word);
            next_word = next_word + 8'h01;
        end
        m_ready = ($urandom_range(99) < ready_pct);
        enable  = ($urandom_range(99) < en_pct);
        if (len_rand && ($urandom_range(7) == 0)) pkt_len = LW'($urandom_range(5));
        rrst_n  = rst_val;
        drive_pins();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_drive(1'b1);
    endtask

    task automatic preload8();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        drive_pins();
    endtask

    task automatic set_knobs(input int r, input int e, input int f);
        ready_pct = r;
        en_pct    = e;
        fill_pct  = f;
    endtask

    // Run until both the FIFO and the skid buffer are empty, bounded.
    task automatic drain();
        int n;
        set_knobs(100, 100, 0);
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || pending_pop) && n < 200) begin
            cycle_drive(1'b1);
            n++;
        end
        check("drain_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        rrst_n      = 1'b0;
        enable      = 1'b0;
        m_ready     = 1'b0;
        pkt_len     = 8'd4;
        fifo_rempty = 1'b1;
        fifo_rdata  = '0;
        set_knobs(0, 0, 0);
        for (int i = 0; i < 3; i++) cycle_drive(1'b0);

        // Streaming: eight words, four-beat packets, no backpressure.
        set_knobs(100, 100, 0);
        run(1);
        preload8();
        run(12);

        // Backpressure then release.
        set_knobs(0, 100, 0);
        preload8();
        run(6);
        set_knobs(100, 100, 0);
        run(12);

        // Length change mid-packet, then zero length.
        pkt_len = 8'd3;
        preload8();
        run(2);
        pkt_len = 8'd2;
        run(10);
        pkt_len = 8'd0;
        preload8();
        run(10);

        // Enable gating with a full buffer and an incomplete packet.
        pkt_len = 8'd5;
        set_knobs(0, 100, 0);
        preload8();
        run(4);
        set_knobs(100, 0, 0);
        run(5);
        set_knobs(100, 100, 0);
        drain();

        // Async reset in the middle of a stalled stream.
        set_knobs(0, 100, 0);
        preload8();
        run(4);
        cycle_drive(1'b0);
        run(0);
        set_knobs(0, 0, 0);
        cycle_drive(1'b0);
        fifo_q.delete();
        drive_pins();
        run(3);
        set_knobs(100, 100, 0);
        run(3);

        // Randomised traffic with varying lengths and handshakes.
        len_rand = 1'b1;
        for (int p = 0; p < 6; p++) begin
            set_knobs(int'($urandom_range(20, 100)), int'($urandom_range(30, 100)),
                      int'($urandom_range(20, 90)));
            run(150);
        end
        len_rand = 1'b0;
        drain();
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/fifo_rd_framer.md
Name: fifo_rd_framer

Overview:
- Read-domain consumer placed directly after the async FIFO.
- Pops words through the FIFO's rinc/rempty/rdata interface and holds them in a 2-entry skid buffer.
- Presents them on a valid/ready stream with registered outputs and tags every pkt_len-th beat as last.
- Decouples downstream backpressure from the FIFO pop path: fifo_rinc never depends on m_ready.

Parameters:
- DATA_WIDTH, 8, width of the FIFO data word and m_data.
- LEN_WIDTH, 8, width of pkt_len and of the internal beat counter.
- CNT_WIDTH, 16, width of the delivered-beat counter word_cnt.

Ports:
- rclk  input  1  read-domain clock; the single clock of the block.
- rrst_n  input  1  asynchronous active-low reset.
- enable  input  1  allows new pops from the FIFO; buffered words still drain when low.
- pkt_len  input  LEN_WIDTH  beats per packet; 0 is treated as 1.
- fifo_rdata  input  DATA_WIDTH  FIFO head word; valid whenever fifo_rempty=0.
- fifo_rempty  input  1  FIFO empty flag.
- fifo_rinc  output  1  pop strobe to the FIFO.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  DATA_WIDTH  output beat data.
- m_last  output  1  final beat of a packet.
- word_cnt  output  CNT_WIDTH  beats accepted downstream, wrapping.
- busy  output  1  buffer non-empty or packet in progress.

Behaviour:
- Reset (async assert, release synchronous to rclk):
  - occ=0, m_valid=0, m_data=0, m_last=0, word_cnt=0, beat_cnt=0, busy=0.
  - fifo_rinc=0 while rrst_n=0.
  - Buffered words are discarded.
- Storage:
  - Slot A is the head and drives m_data/m_last directly from registers.
  - Slot B is the skid slot.
  - Each slot stores {last, data}.
  - occ register takes values 0 (EMPTY), 1 (ONE), 2 (FULL).
- Signal equations:
  - fifo_rinc = enable & ~fifo_rempty & (occ != 2). It is combinational from registered state only.
  - push = fifo_rinc.
  - pop = m_valid & m_ready.
  - m_valid = (occ != 0).
- State transitions:
  - EMPTY + push -> ONE; A <= word.
  - ONE + push, no pop -> FULL; B <= word.
  - ONE + push + pop -> ONE; A <= word.
  - ONE + pop, no push -> EMPTY.
  - FULL + pop -> ONE; A <= B. No push is possible in FULL.
  - No push/pop -> hold.
- Latency: a word popped at edge n appears on m_data with m_valid=1 after edge n. Sustained throughput is 1 beat/cycle when m_ready=1 and the FIFO is non-empty.
- Stream rule: while m_valid=1 and m_ready=0, m_data and m_last hold stable. The output never drops or duplicates a beat.
- Framing, evaluated at push:
  - If beat_cnt==0, latch len_cur = max(pkt_len, 1); otherwise use the latched len_cur.
  - last = (beat_cnt == len_cur-1).
  - beat_cnt <= last ? 0 : beat_cnt+1.
  - Changes to pkt_len mid-packet take effect at the next packet.
- word_cnt increments on each pop and wraps modulo 2^CNT_WIDTH.
- busy = (occ != 0) | (beat_cnt != 0).
- enable low:
  - No pushes.
  - occ drains through pops.
  - beat_cnt is retained, so the packet resumes when enable returns.
- fifo_rempty=1: no push; slots unaffected.

Test Plan:
- Reset: assert rrst_n=0 mid-stream with occ=2 -> immediately m_valid=0, fifo_rinc=0, word_cnt=0. After release with FIFO empty, outputs stay 0 and busy=0.
- Streaming: FIFO preloaded 0x01..0x08, pkt_len=4, m_ready=1, enable=1 -> eight consecutive beats one cycle after the first pop. m_last=1 only on 0x04 and 0x08. word_cnt=8, busy=0 at end.
- Backpressure: same preload, m_ready=0 for 6 cycles -> exactly 2 fifo_rinc pulses, then fifo_rinc=0 and m_data holds 0x01. Release m_ready -> beats 0x01,0x02,0x03,... in order with no gap, loss or duplicate.
- Length change: pkt_len=3, changed to 2 after the first beat is pushed -> m_last on beats 3, 5, 7. pkt_len=0 -> m_last on every beat.
- Enable gating: occ=2, deassert enable, m_ready=1 -> 2 beats delivered, then m_valid=0 and fifo_rinc=0 while the FIFO is non-empty. busy=1 if the packet is incomplete. Re-enable -> packet completes with correct m_last position.
- Counter wrap (CNT_WIDTH=4): 17 accepted beats -> word_cnt=1.
